// File: rtl/uart_adder_engine.sv
// uart_adder_engine: UART-fed adder/subtractor; receives {cmd, A, B} and transmits back {carry/borrow, result}
// Ports: clk, rst (async, active high); rx/tx 8N1 UART lines, idle high;
//        result (WIDTH+1, MSB = carry or borrow), result_valid (pulse when result updates),
//        busy (command accepted until last response stop bit), frame_err (pulse on bad stop bit or timeout)
module uart_adder_engine #(
    parameter int WIDTH        = 64,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    output logic           tx,
    output logic [WIDTH:0] result,
    output logic           result_valid,
    output logic           busy,
    output logic           frame_err
);
    localparam int NB  = WIDTH / 8;
    localparam int BW  = $clog2(NB + 1);
    localparam int RCW = $clog2(CLKS_PER_BIT);
    localparam int CW  = $clog2(20 * CLKS_PER_BIT);
    localparam logic [RCW-1:0] HALF_M1 = RCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RCW-1:0] FULL_M1 = RCW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  TO_M1   = CW'(20 * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  LAST    = BW'(NB - 1);
    localparam logic [BW-1:0]  NB_V    = BW'(NB);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, SEND} state_t;
    state_t state_q, state_d;

    logic [1:0]     sync_q, arm_q;
    logic           rx_prev_q, rx_act_q;
    logic [RCW-1:0] rx_cnt_q;
    logic [3:0]     rx_bit_q;
    logic [7:0]     rx_sh_q;
    logic           rx_s, rx_tick, byte_vld, stop_err;

    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    to_q, to_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             valid_q, valid_d, err_q, err_d;
    logic             tx_q, tx_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [RCW-1:0]   tx_cnt_q, tx_cnt_d;

    logic [WIDTH:0]   rca, cla, csa, sub, calc;
    logic [WIDTH-1:0] g, p;
    logic             cy;

    assign rx_s     = sync_q[1];
    // rx_bit_q: 0 = start, 1..8 = data, 9 = stop; the start bit is checked half a bit in
    assign rx_tick  = rx_act_q && rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF_M1 : FULL_M1);
    assign byte_vld = rx_tick && rx_bit_q == 4'd9 && rx_s;
    assign stop_err = rx_tick && rx_bit_q == 4'd9 && !rx_s;

    // arm_q waits two cycles for the synchroniser to hold real samples, then for rx to idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            arm_q     <= '0;
            rx_prev_q <= 1'b0;
            rx_act_q  <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            if (arm_q != 2'd3 && (arm_q != 2'd2 || rx_s)) arm_q <= arm_q + 2'd1;
            if (!rx_act_q) begin
                rx_act_q <= arm_q == 2'd3 && rx_prev_q && !rx_s;
                rx_cnt_q <= '0;
                rx_bit_q <= '0;
            end else if (rx_tick) begin
                rx_cnt_q <= '0;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_sh_q <= {rx_s, rx_sh_q[7:1]};
                if ((rx_bit_q == 4'd0 && rx_s) || rx_bit_q == 4'd9) rx_act_q <= 1'b0;
            end else begin
                rx_cnt_q <= rx_cnt_q + RCW'(1);
            end
        end
    end

    // ripple chain, Kogge-Stone prefix carries, and a 3:2 compressor stage feeding one final add
    always_comb begin
        cy = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            rca[i] = a_q[i] ^ b_q[i] ^ cy;
            cy     = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
        end
        rca[WIDTH] = cy;
        g = a_q & b_q;
        p = a_q ^ b_q;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            g = g | (p & (g << s));
            p = p & (p << s);
        end
        cla = {g[WIDTH-1], (a_q ^ b_q) ^ {g[WIDTH-2:0], 1'b0}};
    end

    assign csa  = {1'b0, a_q ^ b_q} + {a_q & b_q, 1'b0};
    assign sub  = {1'b0, a_q} - {1'b0, b_q};
    assign calc = mode_q == 2'd0 ? rca : mode_q == 2'd1 ? cla : mode_q == 2'd2 ? csa : sub;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        to_d     = '0;
        result_d = result_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        tx_d     = tx_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q;
        case (state_q)
            IDLE: begin
                err_d = stop_err;
                if (byte_vld) begin
                    mode_d  = rx_sh_q[1:0];
                    idx_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                to_d = rx_act_q ? '0 : to_q + CW'(1);
                if (stop_err || to_q == TO_M1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (byte_vld) begin
                    if (state_q == LOAD_A) a_d[{idx_q, 3'b000} +: 8] = rx_sh_q;
                    else b_d[{idx_q, 3'b000} +: 8] = rx_sh_q;
                    idx_d = idx_q == LAST ? '0 : idx_q + BW'(1);
                    if (idx_q == LAST) state_d = state_q == LOAD_A ? LOAD_B : CALC;
                end
            end
            CALC: begin
                result_d = calc;
                valid_d  = 1'b1;
                tx_d     = 1'b0;
                tx_sh_d  = calc[7:0];
                tx_bit_d = '0;
                tx_cnt_d = '0;
                idx_d    = '0;
                state_d  = SEND;
            end
            SEND: begin
                // tx_bit_q: 0 = start, 1..8 = data, 9 = stop; idx_q == NB_V is the carry/borrow byte
                if (tx_cnt_q != FULL_M1) begin
                    tx_cnt_d = tx_cnt_q + RCW'(1);
                end else begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 4'd1;
                    if (tx_bit_q < 4'd8) begin
                        tx_d    = tx_sh_q[0];
                        tx_sh_d = tx_sh_q >> 1;
                    end else if (tx_bit_q == 4'd8) begin
                        tx_d = 1'b1;
                    end else if (idx_q == NB_V) begin
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + BW'(1);
                        tx_bit_d = '0;
                        tx_d     = 1'b0;
                        tx_sh_d  = idx_q == LAST ? {7'b0, result_q[WIDTH]} : result_q[{idx_q + BW'(1), 3'b000} +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            to_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tx_q     <= 1'b1;
            tx_sh_q  <= '0;
            tx_bit_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tx_q     <= tx_d;
            tx_sh_q  <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    assign tx           = tx_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = state_q != IDLE;
endmodule
